// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the EX-stage multiply/divide engine.
package muldiv_pkg;

  localparam int unsigned DATA_W_DEF     = 32;
  // Start edge to done cycle: DATA_W iterations + FIX + DONE.
  localparam int unsigned MULDIV_LATENCY = DATA_W_DEF + 2;
  // Quotient reported for a zero divisor.
  localparam logic [DATA_W_DEF-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative datapath: one shift-add (multiply) or restoring
// shift-subtract (divide) step per step_en on a 2*DATA_W+1 accumulator.
module muldiv_iter_core #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              div_mode,
  input  logic              step_en,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] res_hi,
  output logic [DATA_W-1:0] res_lo
);

  localparam int unsigned ACC_W = 2 * DATA_W + 1;

  logic [ACC_W-1:0]  acc;
  logic [DATA_W-1:0] opnd;    // multiplicand (mul) or divisor (div)
  logic              div_q;

  logic [DATA_W:0]   add_sum_c;
  logic [ACC_W-1:0]  shl_c;
  logic [DATA_W+1:0] diff_c;
  logic [ACC_W-1:0]  acc_next_c;

  // One iteration: mul adds into the upper half then shifts right;
  // div shifts left and keeps the trial subtraction when it does not borrow.
  always_comb begin
    if (acc[0]) begin
      add_sum_c = acc[ACC_W-1:DATA_W] + {1'b0, opnd};
    end else begin
      add_sum_c = acc[ACC_W-1:DATA_W];
    end
    shl_c  = {acc[ACC_W-2:0], 1'b0};
    diff_c = {1'b0, shl_c[ACC_W-1:DATA_W]} - {2'b00, opnd};
    if (div_q) begin
      if (diff_c[DATA_W+1]) begin
        acc_next_c = shl_c;
      end else begin
        acc_next_c = {diff_c[DATA_W:0], shl_c[DATA_W-1:1], 1'b1};
      end
    end else begin
      acc_next_c = {1'b0, add_sum_c, acc[DATA_W-1:1]};
    end
  end

  // Accumulator and operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      opnd  <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      acc   <= {{(DATA_W + 1){1'b0}}, (div_mode ? op_a : op_b)};
      opnd  <= div_mode ? op_b : op_a;
      div_q <= div_mode;
    end else if (step_en) begin
      acc <= acc_next_c;
    end
  end

  assign res_hi = acc[2*DATA_W-1:DATA_W];
  assign res_lo = acc[DATA_W-1:0];

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: FSM, sign handling, pipeline stall and HI/LO.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_EX,
  input  logic [1:0]        op_EX,
  input  logic [DATA_W-1:0] rs_data_EX,
  input  logic [DATA_W-1:0] rt_data_EX,
  input  logic              flush,
  output logic              stall_req,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  muldiv_state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic              neg_q;       // result (product / quotient) is negative
  logic              a_neg_q;     // remainder takes the dividend's sign
  logic              is_div_q;
  logic              div0_q;
  logic [DATA_W-1:0] rs_raw_q;

  logic              accept_c;
  logic              is_div_c;
  logic              signed_op_c;
  logic              a_neg_c;
  logic              b_neg_c;
  logic [DATA_W-1:0] a_mag_c;
  logic [DATA_W-1:0] b_mag_c;
  logic              step_c;
  logic              fix_wr_c;

  logic [DATA_W-1:0]   core_hi;
  logic [DATA_W-1:0]   core_lo;
  logic [2*DATA_W-1:0] prod_c;
  logic [2*DATA_W-1:0] prod_fix_c;
  logic [DATA_W-1:0]   quot_fix_c;
  logic [DATA_W-1:0]   rem_fix_c;

  // Operand decode; the unsigned view of a negated most-negative value is exact.
  always_comb begin
    is_div_c    = (op_EX == OP_DIV) || (op_EX == OP_DIVU);
    signed_op_c = (op_EX == OP_MULT) || (op_EX == OP_DIV);
    a_neg_c     = signed_op_c & rs_data_EX[DATA_W-1];
    b_neg_c     = signed_op_c & rt_data_EX[DATA_W-1];
    a_mag_c     = a_neg_c ? -rs_data_EX : rs_data_EX;
    b_mag_c     = b_neg_c ? -rt_data_EX : rt_data_EX;
    accept_c    = start_EX & ~flush & ((state_q == IDLE) || (state_q == DONE));
    step_c      = (state_q == MUL) || (state_q == DIV);
  end

  // Next state; flush overrides everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_c) begin
          state_d = is_div_c ? DIV : MUL;
        end else begin
          state_d = IDLE;
        end
      end
      MUL, DIV: begin
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = FIX;
        end
      end
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  // Hold the front of the pipe from acceptance through FIX; DONE lets it advance once.
  assign stall_req = (start_EX & ~flush & (state_q == IDLE)) ||
                     (state_q == MUL) || (state_q == DIV) || (state_q == FIX);

  // Sign correction of the unsigned core result.
  always_comb begin
    prod_c     = {core_hi, core_lo};
    prod_fix_c = neg_q ? -prod_c : prod_c;
    quot_fix_c = neg_q ? -core_lo : core_lo;
    rem_fix_c  = a_neg_q ? -core_hi : core_hi;
    fix_wr_c   = (state_q == FIX) && (state_d == DONE);
  end

  muldiv_iter_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_c),
    .div_mode (is_div_c),
    .step_en  (step_c),
    .op_a     (a_mag_c),
    .op_b     (b_mag_c),
    .res_hi   (core_hi),
    .res_lo   (core_lo)
  );

  // State, iteration count, captured flags, status outputs and HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      a_neg_q     <= 1'b0;
      is_div_q    <= 1'b0;
      div0_q      <= 1'b0;
      rs_raw_q    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      state_q     <= state_d;
      busy        <= (state_d != IDLE);
      done        <= (state_d == DONE);
      div_by_zero <= (state_d == DONE) & div0_q;
      if (accept_c) begin
        cnt_q    <= '0;
        neg_q    <= a_neg_c ^ b_neg_c;
        a_neg_q  <= a_neg_c;
        is_div_q <= is_div_c;
        div0_q   <= is_div_c & (rt_data_EX == '0);
        rs_raw_q <= rs_data_EX;
      end else if (step_c) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (fix_wr_c) begin
        if (is_div_q && div0_q) begin
          hi <= rs_raw_q;
          lo <= '1;
        end else if (is_div_q) begin
          hi <= rem_fix_c;
          lo <= quot_fix_c;
        end else begin
          hi <= prod_fix_c[2*DATA_W-1:DATA_W];
          lo <= prod_fix_c[DATA_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_EX;
  logic [1:0]  op_EX;
  logic [31:0] rs_data_EX;
  logic [31:0] rt_data_EX;
  logic        flush;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  ex_muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_EX    (start_EX),
    .op_EX       (op_EX),
    .rs_data_EX  (rs_data_EX),
    .rt_data_EX  (rt_data_EX),
    .flush       (flush),
    .stall_req   (stall_req),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present an op in cycle 0 (just after a posedge); returns just after the accepting edge.
  task automatic start_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    start_EX = 1'b1; op_EX = op; rs_data_EX = a; rt_data_EX = b;
    @(negedge clk);
    check({tag, "_stall0"}, 64'(stall_req), 64'd1);
    @(posedge clk); #1;
    start_EX = 1'b0; op_EX = 2'b00; rs_data_EX = 32'hDEAD_BEEF; rt_data_EX = 32'h0;
  endtask

  // Entered just after the accepting edge (cycle 1); checks the done cycle and the one after.
  task automatic wait_result(input string tag, input logic [31:0] e_hi, input logic [31:0] e_lo,
                             input logic e_dz, input logic next_busy);
    int lat;
    int stall_lo;
    stall_lo = 0;
    for (lat = 1; lat <= 60; lat++) begin
      @(negedge clk);
      if (done) break;
      if (!stall_req) stall_lo++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd34);
    check({tag, "_stall_busy"}, 64'(stall_lo), 64'd0);
    check({tag, "_stall_done"}, 64'(stall_req), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(e_hi));
    check({tag, "_lo"}, 64'(lo), 64'(e_lo));
    check({tag, "_dz"}, 64'(div_by_zero), 64'(e_dz));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_busy_after"}, 64'(busy), 64'(next_busy));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n_done;
    rst = 1'b1; start_EX = 1'b0; op_EX = 2'b00; rs_data_EX = '0; rt_data_EX = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi",    64'(hi), 64'd0);
    check("rst_lo",    64'(lo), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_dz",    64'(div_by_zero), 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Signed multiply: 7 * -3 = -21
    start_op("mult_neg", 2'b00, 32'd7, 32'hFFFF_FFFD);
    wait_result("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);

    // Unsigned max * max
    start_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);

    // Signed divide: -7 / 2 -> q=-3, r=-1
    start_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_result("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);

    // Signed overflow: most-negative / -1
    start_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("div_ovf", 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);

    // Divide by zero keeps full latency
    start_op("divu_zero", 2'b11, 32'd100, 32'd0);
    wait_result("divu_zero", 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1'b0);

    // Known HI/LO: 0x451 / 0x20 -> q=0x22, r=0x11
    start_op("divu_load", 2'b11, 32'h451, 32'h20);
    wait_result("divu_load", 32'h11, 32'h22, 1'b0, 1'b0);

    // Flush at iteration 10
    start_op("flush", 2'b11, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    check("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    check("flush_stall", 64'(stall_req), 64'd0);
    check("flush_hi", 64'(hi), 64'h11);
    check("flush_lo", 64'(lo), 64'h22);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("flush_no_done", 64'(n_done), 64'd0);
    check("flush_hi_kept", 64'(hi), 64'h11);

    // Flush wins over a simultaneous start
    @(posedge clk); #1;
    start_EX = 1'b1; flush = 1'b1; op_EX = 2'b00; rs_data_EX = 32'd2; rt_data_EX = 32'd3;
    #1;
    check("flush_start_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    start_EX = 1'b0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("flush_start_busy2", 64'(busy), 64'd0);
    check("flush_start_lo", 64'(lo), 64'h22);

    // Reset mid-operation
    start_op("rst_mid", 2'b01, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_hi",    64'(hi), 64'd0);
    check("rstmid_lo",    64'(lo), 64'd0);
    check("rstmid_busy",  64'(busy), 64'd0);
    check("rstmid_done",  64'(done), 64'd0);
    check("rstmid_dz",    64'(div_by_zero), 64'd0);
    check("rstmid_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;

    // Back-to-back: start held high with the next op's operands through the DONE cycle
    start_op("b2b_first", 2'b01, 32'd6, 32'd7);
    start_EX = 1'b1; op_EX = 2'b01; rs_data_EX = 32'd3; rt_data_EX = 32'd5;
    wait_result("b2b_first", 32'd0, 32'd42, 1'b0, 1'b1);
    start_EX = 1'b0; op_EX = 2'b00; rs_data_EX = 32'hDEAD_BEEF; rt_data_EX = 32'h0;
    wait_result("b2b_second", 32'd0, 32'd15, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
